// File: rtl/dsp_seq_divider_if.sv
// START/DONE handshake bundle for dsp_seq_divider: operands in, status and results out.
interface dsp_seq_divider_if #(
  parameter int DW = 36,
  parameter int VW = 18
);
  logic          START;
  logic [DW-1:0] DIVIDEND;
  logic [VW-1:0] DIVISOR;
  logic          BUSY;
  logic          DONE;
  logic          DIVZERO;
  logic [DW-1:0] QUOTIENT;
  logic [VW-1:0] REMAINDER;

  modport master (
    output START, DIVIDEND, DIVISOR,
    input  BUSY, DONE, DIVZERO, QUOTIENT, REMAINDER
  );

  modport slave (
    input  START, DIVIDEND, DIVISOR,
    output BUSY, DONE, DIVZERO, QUOTIENT, REMAINDER
  );
endinterface

// File: rtl/dsp_seq_divider.sv
// Iterative radix-2 restoring divider (DW-bit dividend / VW-bit divisor), one quotient bit
// per enabled clock, sharing the DSP slice clock-enable.
module dsp_seq_divider #(
  parameter int DW     = 36,
  parameter int VW     = 18,
  parameter int SIGNED = 0
) (
  input  logic               PCLK,
  input  logic               PRST,
  input  logic               PCE,
  dsp_seq_divider_if.slave   bus
);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, RUN, ZERO} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dq_q, dq_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW-1:0] pr_q, pr_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          divzero_q, divzero_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;

  logic          dvd_neg, dvs_neg;
  logic [DW-1:0] dvd_abs;
  logic [VW-1:0] dvs_abs;
  logic [VW:0]   pr_shift;
  logic          pr_ge;
  logic [VW-1:0] pr_next;
  logic [DW-1:0] q_mag;

  // dq_q starts as the dividend and fills with quotient bits from the LSB as it shifts out;
  // the partial remainder stays below the divisor, so only pr' needs the extra bit.
  always_comb begin
    dvd_neg  = (SIGNED != 0) && bus.DIVIDEND[DW-1];
    dvs_neg  = (SIGNED != 0) && bus.DIVISOR[VW-1];
    dvd_abs  = dvd_neg ? -bus.DIVIDEND : bus.DIVIDEND;
    dvs_abs  = dvs_neg ? -bus.DIVISOR : bus.DIVISOR;
    pr_shift = {pr_q, dq_q[DW-1]};
    pr_ge    = pr_shift >= {1'b0, dvs_q};
    pr_next  = pr_ge ? (pr_shift[VW-1:0] - dvs_q) : pr_shift[VW-1:0];
    q_mag    = {dq_q[DW-2:0], pr_ge};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dq_d      = dq_q;
    dvs_d     = dvs_q;
    pr_d      = pr_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    busy_d    = busy_q;
    done_d    = done_q;
    divzero_d = divzero_q;
    quo_d     = quo_q;
    rem_d     = rem_q;

    if (PCE) begin
      done_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.START) begin
            dq_d    = dvd_abs;
            dvs_d   = dvs_abs;
            pr_d    = '0;
            qneg_d  = dvd_neg ^ dvs_neg;
            rneg_d  = dvd_neg;
            cnt_d   = CW'(DW);
            busy_d  = 1'b1;
            state_d = (bus.DIVISOR == '0) ? ZERO : RUN;
          end
        end
        RUN: begin
          dq_d  = q_mag;
          pr_d  = pr_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quo_d     = qneg_q ? -q_mag : q_mag;
            rem_d     = rneg_q ? -pr_next : pr_next;
            divzero_d = 1'b0;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end
        end
        ZERO: begin
          cnt_d     = '0;
          quo_d     = '1;
          rem_d     = '0;
          divzero_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRST) begin
    if (!PRST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dq_q      <= '0;
      dvs_q     <= '0;
      pr_q      <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dq_q      <= dq_d;
      dvs_q     <= dvs_d;
      pr_q      <= pr_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
    end
  end

  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.DIVZERO   = divzero_q;
  assign bus.QUOTIENT  = quo_q;
  assign bus.REMAINDER = rem_q;
endmodule

// File: tb/tb_dsp_seq_divider.sv
// Bench for dsp_seq_divider: unsigned and signed instances share stimulus and are checked
// every cycle against an arithmetic reference with operation-level timing.
module tb_dsp_seq_divider;
  localparam int DW = 36;
  localparam int VW = 18;

  logic PCLK;
  logic PRST;
  logic PCE;

  int checks   = 0;
  int failures = 0;

  dsp_seq_divider_if #(.DW(DW), .VW(VW)) bus_u ();
  dsp_seq_divider_if #(.DW(DW), .VW(VW)) bus_s ();

  dsp_seq_divider #(.DW(DW), .VW(VW), .SIGNED(0)) u_dut_u (
    .PCLK(PCLK), .PRST(PRST), .PCE(PCE), .bus(bus_u)
  );
  dsp_seq_divider #(.DW(DW), .VW(VW), .SIGNED(1)) u_dut_s (
    .PCLK(PCLK), .PRST(PRST), .PCE(PCE), .bus(bus_s)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                          input bit sgn);
    longint sa, sb;
    if (b == '0) return '1;
    if (!sgn) return a / b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return DW'(sa / sb);
  endfunction

  function automatic logic [VW-1:0] ref_r(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                          input bit sgn);
    longint sa, sb;
    if (b == '0) return '0;
    if (!sgn) return VW'(a % b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return VW'(sa % sb);
  endfunction

  // Reference: one operation in flight, result appears after DW enabled edges (1 for /0).
  logic          m_busy, m_done, m_dz, p_dz;
  int            m_left;
  logic [DW-1:0] m_q [2];
  logic [VW-1:0] m_r [2];
  logic [DW-1:0] p_q [2];
  logic [VW-1:0] p_r [2];

  always @(posedge PCLK or negedge PRST) begin
    if (!PRST) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      p_dz   <= 1'b0;
      m_left <= 0;
      for (int i = 0; i < 2; i++) begin
        m_q[i] <= '0;
        m_r[i] <= '0;
        p_q[i] <= '0;
        p_r[i] <= '0;
      end
    end else if (PCE) begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_dz   <= p_dz;
          for (int i = 0; i < 2; i++) begin
            m_q[i] <= p_q[i];
            m_r[i] <= p_r[i];
          end
        end
      end else if (bus_u.START) begin
        m_busy <= 1'b1;
        m_left <= (bus_u.DIVISOR == '0) ? 1 : DW;
        p_dz   <= (bus_u.DIVISOR == '0);
        for (int i = 0; i < 2; i++) begin
          p_q[i] <= ref_q(bus_u.DIVIDEND, bus_u.DIVISOR, i == 1);
          p_r[i] <= ref_r(bus_u.DIVIDEND, bus_u.DIVISOR, i == 1);
        end
      end
    end
  end

  always @(negedge PCLK) begin
    chk("busy_u", bus_u.BUSY,      m_busy);
    chk("done_u", bus_u.DONE,      m_done);
    chk("dz_u",   bus_u.DIVZERO,   m_dz);
    chk("quo_u",  bus_u.QUOTIENT,  m_q[0]);
    chk("rem_u",  bus_u.REMAINDER, m_r[0]);
    chk("busy_s", bus_s.BUSY,      m_busy);
    chk("done_s", bus_s.DONE,      m_done);
    chk("dz_s",   bus_s.DIVZERO,   m_dz);
    chk("quo_s",  bus_s.QUOTIENT,  m_q[1]);
    chk("rem_s",  bus_s.REMAINDER, m_r[1]);
  end

  task automatic drive(input logic st, input logic [DW-1:0] a, input logic [VW-1:0] b);
    bus_u.START = st;  bus_u.DIVIDEND = a;  bus_u.DIVISOR = b;
    bus_s.START = st;  bus_s.DIVIDEND = a;  bus_s.DIVISOR = b;
  endtask

  // Called at a falling edge; returns at the falling edge where DONE is seen (or on timeout).
  task automatic do_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input int stall_at,
                       input int poke_at, output int lat);
    drive(1'b1, a, b);
    @(negedge PCLK);
    drive(1'b0, a, b);
    lat = 0;
    while (lat < 100) begin
      @(negedge PCLK);
      lat++;
      if (bus_u.DONE) break;
      if (stall_at > 0 && lat == stall_at)     PCE = 1'b0;
      if (stall_at > 0 && lat == stall_at + 5) PCE = 1'b1;
      if (poke_at > 0 && lat == poke_at)       drive(1'b1, 36'd50, 18'd5);
      if (poke_at > 0 && lat == poke_at + 1)   drive(1'b0, 36'd50, 18'd5);
    end
  endtask

  int lat;
  int n_done;

  initial begin
    PRST = 1'b0;
    PCE  = 1'b1;
    drive(1'b0, '0, '0);
    repeat (3) @(negedge PCLK);
    chk("rst_busy", bus_u.BUSY, 1'b0);
    chk("rst_done", bus_u.DONE, 1'b0);
    chk("rst_quo",  bus_u.QUOTIENT, 36'd0);
    chk("rst_rem",  bus_s.REMAINDER, 18'd0);
    #2 PRST = 1'b1;
    @(negedge PCLK);

    do_op(36'd1000, 18'd7, 0, 0, lat);
    chk("basic_lat", lat, 36);
    chk("basic_quo", bus_u.QUOTIENT, 36'd142);
    chk("basic_rem", bus_u.REMAINDER, 18'd6);
    chk("basic_dz",  bus_u.DIVZERO, 1'b0);
    @(negedge PCLK);

    do_op(36'hF_FFFF_FFFF, 18'd1, 0, 0, lat);
    chk("max_quo", bus_u.QUOTIENT, 36'hF_FFFF_FFFF);
    chk("max_rem", bus_u.REMAINDER, 18'd0);
    do_op(36'd5, 18'h3FFFF, 0, 0, lat);
    chk("bigdiv_quo", bus_u.QUOTIENT, 36'd0);
    chk("bigdiv_rem", bus_u.REMAINDER, 18'd5);
    @(negedge PCLK);

    do_op(36'd123, 18'd0, 0, 0, lat);
    chk("dz_lat", lat, 1);
    chk("dz_quo", bus_u.QUOTIENT, 36'hF_FFFF_FFFF);
    chk("dz_rem", bus_u.REMAINDER, 18'd0);
    chk("dz_flag", bus_u.DIVZERO, 1'b1);
    @(negedge PCLK);

    do_op(36'd1000, 18'd7, 0, 5, lat);
    chk("poke_lat", lat, 36);
    chk("poke_quo", bus_u.QUOTIENT, 36'd142);
    chk("poke_rem", bus_u.REMAINDER, 18'd6);
    do_op(36'd50, 18'd5, 0, 0, lat);
    chk("b2b_lat", lat, 36);
    chk("b2b_quo", bus_u.QUOTIENT, 36'd10);
    chk("b2b_rem", bus_u.REMAINDER, 18'd0);
    @(negedge PCLK);

    do_op(36'd1000, 18'd7, 10, 0, lat);
    chk("stall_lat", lat, 41);
    chk("stall_quo", bus_u.QUOTIENT, 36'd142);
    chk("stall_rem", bus_u.REMAINDER, 18'd6);
    @(negedge PCLK);

    do_op(36'hF_FFFF_FFF9, 18'd2, 0, 0, lat);
    chk("s_m7d2_lat", lat, 36);
    chk("s_m7d2_quo", bus_s.QUOTIENT, 36'hF_FFFF_FFFD);
    chk("s_m7d2_rem", bus_s.REMAINDER, 18'h3FFFF);
    do_op(36'd7, 18'h3FFFE, 0, 0, lat);
    chk("s_7dm2_quo", bus_s.QUOTIENT, 36'hF_FFFF_FFFD);
    chk("s_7dm2_rem", bus_s.REMAINDER, 18'd1);
    do_op(36'h8_0000_0000, 18'h3FFFF, 0, 0, lat);
    chk("s_min_quo", bus_s.QUOTIENT, 36'h8_0000_0000);
    chk("s_min_rem", bus_s.REMAINDER, 18'd0);
    chk("s_min_dz",  bus_s.DIVZERO, 1'b0);
    @(negedge PCLK);

    drive(1'b1, 36'd1000, 18'd7);
    @(negedge PCLK);
    drive(1'b0, 36'd1000, 18'd7);
    repeat (20) @(negedge PCLK);
    #2 PRST = 1'b0;
    #1;
    chk("abort_busy", bus_u.BUSY, 1'b0);
    chk("abort_quo_s", bus_s.QUOTIENT, 36'd0);
    chk("abort_quo_u", bus_u.QUOTIENT, 36'd0);
    chk("abort_rem_u", bus_u.REMAINDER, 18'd0);
    @(negedge PCLK);
    #2 PRST = 1'b1;
    n_done = 0;
    repeat (50) begin
      @(negedge PCLK);
      if (bus_u.DONE || bus_s.DONE) n_done++;
    end
    chk("abort_no_done", n_done, 0);

    repeat (3000) begin
      logic [DW-1:0] a;
      logic [VW-1:0] b;
      int sel;
      @(negedge PCLK);
      PCE = ($urandom_range(0, 7) != 0);
      a   = DW'({$urandom, $urandom});
      sel = $urandom_range(0, 15);
      if (sel == 0)      b = '0;
      else if (sel < 5)  b = VW'($urandom_range(1, 15));
      else if (sel == 5) b = '1;
      else               b = VW'($urandom);
      if ($urandom_range(0, 7) == 0) a = DW'($urandom_range(0, 300));
      drive($urandom_range(0, 3) == 0, a, b);
    end

    @(negedge PCLK);
    PCE = 1'b1;
    drive(1'b0, '0, '0);
    repeat (60) @(negedge PCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
